fifo_drain_ctrl: RTL and testbench

Read-side burst controller for the byte FIFO fed by the serial-to-parallel receiver. It tracks FIFO occupancy from the write-enable and its own reads, and drains complete bursts of up to BURST_LEN bytes onto a valid/ready byte stream. Each burst's final byte is marked with m_last. The block sits between the FIFO read port (rd_en / data_o / empty) and the downstream packet consumer.

---
 rtl/fifo_drain_ctrl.sv | 121 ++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: drains complete bursts of up to BURST_LEN bytes from a byte FIFO onto a valid/ready stream.
// Define FIFO_DRAIN_CTRL_FLUSH_EN to flush partial bursts after TIMEOUT write-idle cycles.
module fifo_drain_ctrl #(
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         fifo_wr_en,
  input  logic                         fifo_empty,
  input  logic [7:0]                   fifo_data,
  output logic                         fifo_rd_en,
  output logic [7:0]                   m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         err
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] ONE     = LW'(1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] BURST_L = LW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] level_q, level_d, rem_q, rem_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d, m_last_q, m_last_d, err_q, err_d;
  logic          full_burst, flush, start;

  assign full_burst = level_q >= BURST_L;
  assign start      = full_burst | flush;

`ifdef FIFO_DRAIN_CTRL_FLUSH_EN
  logic [7:0] timer_q, timer_d;
  // Counts only while a partial burst sits untouched; saturates at TIMEOUT until the burst starts.
  always_comb begin
    timer_d = '0;
    if (state_q == IDLE && !start && !fifo_wr_en && level_q != '0 && !full_burst)
      timer_d = (timer_q == 8'(TIMEOUT)) ? timer_q : timer_q + 8'd1;
  end
  assign flush = (timer_q == 8'(TIMEOUT)) && level_q != '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) timer_q <= '0;
    else          timer_q <= timer_d;
`else
  assign flush = 1'b0;
`endif

  // Occupancy: simultaneous write and read cancel; writes into a full FIFO are dropped.
  always_comb begin
    level_d = level_q;
    if (fifo_wr_en && !fifo_rd_en && level_q != DEPTH_L) level_d = level_q + ONE;
    else if (!fifo_wr_en && fifo_rd_en && level_q != '0) level_d = level_q - ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      level_q   <= '0;
      rem_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      rem_q     <= rem_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RD;
        rem_d   = full_burst ? BURST_L : level_q;
      end
      RD: begin
        state_d = fifo_empty ? IDLE : CAP;
        rem_d   = fifo_empty ? rem_q : rem_q - ONE;
        err_d   = err_q | fifo_empty;
      end
      CAP: begin
        state_d   = OUT;
        m_data_d  = fifo_data;
        m_valid_d = 1'b1;
        m_last_d  = rem_q == '0;
      end
      OUT: if (m_ready) begin
        state_d   = m_last_q ? IDLE : RD;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = (state_q == RD) && !fifo_empty;
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign level   = level_q;
  assign err     = err_q;
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed bench for fifo_drain_ctrl with a behavioural byte FIFO in front of it.
module tb_fifo_drain_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fifo_wr_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       m_last;
  logic [4:0] level;
  logic       err;
  logic [7:0] wdata = 8'h00;
  logic       force_empty = 1'b0;

  int vectors = 0, miscompares = 0;
  int cyc = 0, last_wr = 0, rd_cnt = 0, rd_b2b = 0, rd_empty = 0, cnt = 0;
  logic prev_rd = 1'b0;
  logic [7:0] fq[$];
  logic [8:0] out_q[$];
  int rd_cyc[$];

  fifo_drain_ctrl dut (
    .clk(clk), .reset_n(reset_n), .fifo_wr_en(fifo_wr_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .level(level), .err(err)
  );

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || cnt == 0;

  // FIFO model plus event log of reads, writes and handshakes.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fq.delete();
      cnt <= 0;
      fifo_data <= 8'h00;
    end else begin
      cyc++;
      if (fifo_rd_en) begin
        if (prev_rd) rd_b2b++;
        if (fifo_empty) rd_empty++;
        rd_cnt++;
        rd_cyc.push_back(cyc);
      end
      prev_rd = fifo_rd_en;
      if (m_valid && m_ready) out_q.push_back({m_last, m_data});
      if (fifo_wr_en) last_wr = cyc;
      if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
      if (fifo_wr_en) fq.push_back(wdata);
      cnt <= fq.size();
    end
  end

  function automatic logic [8:0] outb(input int i);
    return (i < out_q.size()) ? out_q[i] : 9'h1FF;
  endfunction

  function automatic int rdc(input int i);
    return (i < rd_cyc.size()) ? rd_cyc[i] : -1000;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    fifo_wr_en = 1'b1;
    wdata = d;
    tick();
    fifo_wr_en = 1'b0;
  endtask

  task automatic wait_outs(input int n, input string nm);
    int k = 0;
    while (out_q.size() < n && k < 300) begin tick(); k++; end
    vectors++;
    if (out_q.size() < n) begin
      miscompares++;
      $display("FAIL %s_timeout outputs=%0d need=%0d", nm, out_q.size(), n);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({fifo_rd_en, m_valid, m_last, m_data, level, err} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_values rd=%b v=%b l=%b d=%h lvl=%0d err=%b exp all zero", fifo_rd_en, m_valid, m_last, m_data, level, err);
    end
    reset_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({fifo_rd_en, m_valid, level} !== 7'h0) begin
      miscompares++;
      $display("FAIL reset_idle rd=%b v=%b lvl=%0d exp 0 0 0", fifo_rd_en, m_valid, level);
    end
  endtask

  task automatic test_full_burst;
    logic [8:0] exp [4] = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4};
    int r0 = rd_cnt;
    out_q.delete(); rd_cyc.delete();
    wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
    vectors++;
    if (level !== 5'd4) begin miscompares++; $display("FAIL full_level_pre got=%0d exp=4", level); end
    wait_outs(4, "full");
    repeat (2) tick();
    vectors++;
    if (rd_cnt - r0 !== 4) begin miscompares++; $display("FAIL full_rd_count got=%0d exp=4", rd_cnt - r0); end
    vectors++;
    if (rdc(0) - last_wr !== 2) begin miscompares++; $display("FAIL full_start_latency got=%0d exp=2", rdc(0) - last_wr); end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (rdc(i) - rdc(i - 1) !== 3) begin miscompares++; $display("FAIL full_rd_spacing%0d got=%0d exp=3", i, rdc(i) - rdc(i - 1)); end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (outb(i) !== exp[i]) begin miscompares++; $display("FAIL full_byte%0d got=%h exp=%h", i, outb(i), exp[i]); end
    end
    vectors++;
    if (level !== 5'd0) begin miscompares++; $display("FAIL full_level_end got=%0d exp=0", level); end
  endtask

  task automatic test_backpressure;
    logic [8:0] exp [4] = '{9'h0B1, 9'h0B2, 9'h0B3, 9'h1B4};
    int r1, k = 0;
    out_q.delete();
    wr(8'hB1); wr(8'hB2); wr(8'hB3); wr(8'hB4);
    wait_outs(1, "bp_first");
    m_ready = 1'b0;
    while (!m_valid && k < 50) begin tick(); k++; end
    r1 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({m_valid, m_last, m_data} !== 10'h2B2) begin
        miscompares++;
        $display("FAIL bp_hold%0d v=%b l=%b d=%h exp v=1 l=0 d=b2", i, m_valid, m_last, m_data);
      end
      tick();
    end
    vectors++;
    if (rd_cnt !== r1) begin miscompares++; $display("FAIL bp_no_extra_rd got=%0d exp=%0d", rd_cnt, r1); end
    m_ready = 1'b1;
    wait_outs(4, "bp");
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (outb(i) !== exp[i]) begin miscompares++; $display("FAIL bp_byte%0d got=%h exp=%h", i, outb(i), exp[i]); end
    end
    tick();
    vectors++;
    if (level !== 5'd0) begin miscompares++; $display("FAIL bp_level_end got=%0d exp=0", level); end
  endtask

  task automatic test_concurrent;
    logic [8:0] exp [8] = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4, 9'h0C5, 9'h0C6, 9'h0C7, 9'h1C8};
    int r0 = rd_cnt, k = 0;
    out_q.delete();
    wr(8'hC1); wr(8'hC2); wr(8'hC3); wr(8'hC4);
    while (!fifo_rd_en && k < 20) begin tick(); k++; end
    vectors++;
    if (fifo_rd_en !== 1'b1) begin miscompares++; $display("FAIL conc_rd_seen got=%b exp=1", fifo_rd_en); end
    wr(8'hC5);
    vectors++;
    if (level !== 5'd4) begin miscompares++; $display("FAIL conc_level_wr_rd got=%0d exp=4", level); end
    wr(8'hC6);
    vectors++;
    if (level !== 5'd5) begin miscompares++; $display("FAIL conc_level_wr got=%0d exp=5", level); end
    wait_outs(4, "conc1");
    repeat (6) tick();
    vectors++;
    if (level !== 5'd2) begin miscompares++; $display("FAIL conc_level_mid got=%0d exp=2", level); end
    vectors++;
    if (rd_cnt - r0 !== 4) begin miscompares++; $display("FAIL conc_burst1_len got=%0d exp=4", rd_cnt - r0); end
    wr(8'hC7); wr(8'hC8);
    wait_outs(8, "conc2");
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (outb(i) !== exp[i]) begin miscompares++; $display("FAIL conc_byte%0d got=%h exp=%h", i, outb(i), exp[i]); end
    end
    vectors++;
    if (level !== 5'd0 || rd_cnt - r0 !== 8) begin
      miscompares++;
      $display("FAIL conc_end level=%0d reads=%0d exp 0 8", level, rd_cnt - r0);
    end
  endtask

  task automatic test_flush;
    int r0 = rd_cnt;
    out_q.delete(); rd_cyc.delete();
    wr(8'hF1); wr(8'hF2);
`ifdef FIFO_DRAIN_CTRL_FLUSH_EN
    wait_outs(2, "flush");
    repeat (2) tick();
    vectors++;
    if (rdc(0) - last_wr !== 17) begin miscompares++; $display("FAIL flush_latency got=%0d exp=17", rdc(0) - last_wr); end
    vectors++;
    if (rd_cnt - r0 !== 2) begin miscompares++; $display("FAIL flush_rd_count got=%0d exp=2", rd_cnt - r0); end
    vectors++;
    if (outb(0) !== 9'h0F1 || outb(1) !== 9'h1F2) begin
      miscompares++;
      $display("FAIL flush_bytes got=%h %h exp=0f1 1f2", outb(0), outb(1));
    end
    vectors++;
    if (level !== 5'd0) begin miscompares++; $display("FAIL flush_level got=%0d exp=0", level); end
`else
    repeat (40) tick();
    vectors++;
    if (rd_cnt !== r0) begin miscompares++; $display("FAIL noflush_reads got=%0d exp=%0d", rd_cnt, r0); end
    vectors++;
    if (level !== 5'd2 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL noflush_hold level=%0d v=%b exp 2 0", level, m_valid);
    end
`endif
  endtask

  task automatic test_mismatch;
    int r0;
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL mism_err_pre got=%b exp=0", err); end
    force_empty = 1'b1;
    r0 = rd_cnt;
    wr(8'hD1); wr(8'hD2); wr(8'hD3); wr(8'hD4);
    repeat (4) tick();
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL mism_err got=%b exp=1", err); end
    vectors++;
    if (rd_cnt !== r0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mism_no_read reads=%0d v=%b exp %0d 0", rd_cnt, m_valid, r0);
    end
    vectors++;
    if (level !== 5'd4) begin miscompares++; $display("FAIL mism_level got=%0d exp=4", level); end
  endtask

  task automatic test_reset_mid_burst;
    logic [8:0] exp [4] = '{9'h0E1, 9'h0E2, 9'h0E3, 9'h1E4};
    int k = 0, bad = 0;
    force_empty = 1'b0;
    m_ready = 1'b0;
    while (!m_valid && k < 50) begin tick(); k++; end
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 8'hD1) begin
      miscompares++;
      $display("FAIL rmid_in_out v=%b d=%h exp 1 d1", m_valid, m_data);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({fifo_rd_en, m_valid, m_last, m_data, level, err} !== 17'h0) begin
      miscompares++;
      $display("FAIL rmid_async rd=%b v=%b l=%b d=%h lvl=%0d err=%b exp all zero", fifo_rd_en, m_valid, m_last, m_data, level, err);
    end
    m_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_valid || fifo_rd_en) bad++;
      tick();
    end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL rmid_quiet got=%0d active cycles exp=0", bad); end
    out_q.delete();
    wr(8'hE1); wr(8'hE2); wr(8'hE3); wr(8'hE4);
    wait_outs(4, "rmid_recover");
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (outb(i) !== exp[i]) begin miscompares++; $display("FAIL rmid_byte%0d got=%h exp=%h", i, outb(i), exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_backpressure();
    test_concurrent();
    test_flush();
    test_mismatch();
    test_reset_mid_burst();
    repeat (3) tick();
    vectors++;
    if (rd_b2b !== 0 || rd_empty !== 0) begin
      miscompares++;
      $display("FAIL rd_rules back_to_back=%0d while_empty=%0d exp 0 0", rd_b2b, rd_empty);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
